// File: rtl/char_num_gen_if.sv
// rtl/char_num_gen_if.sv - signal bundle between the counter digit source and its users
//
// Purpose: groups the value-load handshake, the pixel-position inputs and the
// character outputs of char_num_gen into one interface.
// Ports (signals):
//   value      VALUE_W  binary value to display
//   value_stb  1        one-cycle load strobe
//   hcount     11       current horizontal pixel position
//   vblnk      1        vertical blanking flag
//   busy       1        conversion in progress
//   char_code  12       character code (ASCII in [6:0])
//   char_xpos  12       left edge of current character cell
//   char_ypos  12       top edge of digit row
//   num_color  12       RGB444 colour
// Modports: master drives value/strobe/position, slave (the block) drives the rest.
interface char_num_gen_if #(
  parameter int VALUE_W = 10
);
  logic [VALUE_W-1:0] value;
  logic               value_stb;
  logic [10:0]        hcount;
  logic               vblnk;
  logic               busy;
  logic [11:0]        char_code;
  logic [11:0]        char_xpos;
  logic [11:0]        char_ypos;
  logic [11:0]        num_color;

  modport master (
    output value, value_stb, hcount, vblnk,
    input  busy, char_code, char_xpos, char_ypos, num_color
  );

  modport slave (
    input  value, value_stb, hcount, vblnk,
    output busy, char_code, char_xpos, char_ypos, num_color
  );
endinterface

// File: rtl/char_num_gen.sv
// rtl/char_num_gen.sv - binary-to-decimal counter text source for the character drawer
//
// Purpose: converts a binary value to decimal with a sequential shift-add-3
// engine, latches new digits onto the screen only on a vblnk rising edge, and
// per pixel column outputs the character code, cell origin and colour.
// Optional feature: define LEADING_ZERO_BLANK_EN to show leading zeros as
// spaces (least significant digit always shown).
// Ports:
//   clk  in  pixel clock
//   rst  in  asynchronous active-high reset
//   bus  char_num_gen_if.slave (value, value_stb, hcount, vblnk in;
//        busy, char_code, char_xpos, char_ypos, num_color out)
module char_num_gen #(
  parameter int          VALUE_W   = 10,
  parameter int          DIGITS    = 3,
  parameter int          PRESCALER = 1,
  parameter int          XPOS      = 0,
  parameter int          YPOS      = 0,
  parameter logic [11:0] COLOR     = 12'hF00
) (
  input logic           clk,
  input logic           rst,
  char_num_gen_if.slave bus
);
  // Enough BCD nibbles for the largest VALUE_W input and never fewer than DIGITS.
  localparam int          BCD_N0 = (VALUE_W + 2) / 3;
  localparam int          BCD_N  = (BCD_N0 > DIGITS) ? BCD_N0 : DIGITS;
  localparam int          BCD_W  = 4 * BCD_N;
  localparam int          DISP_W = 4 * DIGITS;
  localparam int          CNT_W  = $clog2(VALUE_W + 1);
  localparam int          CELL   = 8 * PRESCALER;
  localparam logic [11:0] XPOS12 = 12'(XPOS);
  localparam logic [31:0] LIMIT  = 32'(10 ** DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [VALUE_W-1:0]  sr_q;
  logic [BCD_W-1:0]    bcd_q, bcd_adj, bcd_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic [DISP_W-1:0]   pend_q, disp_q, result;
  logic                pend_valid_q;
  logic                vblnk_q;
  logic                last, rise, load;
  logic [11:0]         rel, idx;
  logic [3:0]          digit, d_i;
  logic                in_range;
  logic [11:0]         code_d, xpos_d, char_code_q, char_xpos_q;
`ifdef LEADING_ZERO_BLANK_EN
  logic                lead, blank;
`endif

  assign load = (state_q == IDLE) && bus.value_stb;
  assign last = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
  assign rise = bus.vblnk && !vblnk_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.value_stb) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  assign bus.busy = (state_q == SHIFT);

  // Add 3 to every nibble >= 5 before the shift (double dabble).
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_nxt = (bcd_adj << 1) | BCD_W'(sr_q[VALUE_W-1]);
  assign result  = ovf_q ? {DIGITS{4'd9}} : bcd_nxt[DISP_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      sr_q  <= bus.value;
      bcd_q <= '0;
      cnt_q <= CNT_W'(VALUE_W);
      ovf_q <= (32'(bus.value) >= LIMIT);
    end else if (state_q == SHIFT) begin
      sr_q  <= sr_q << 1;
      bcd_q <= bcd_nxt;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Pending result waits for a vblnk rising edge; a result finishing on that
  // very edge goes straight to the display and never becomes pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q      <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
    end else begin
      vblnk_q <= bus.vblnk;
      if (last) begin
        pend_q       <= result;
        pend_valid_q <= !rise;
      end else if (rise) begin
        pend_valid_q <= 1'b0;
      end
      if (rise && last)              disp_q <= result;
      else if (rise && pend_valid_q) disp_q <= pend_q;
    end
  end

  // hcount left of XPOS wraps to a huge rel, so it falls out of range naturally.
  assign rel      = 12'(bus.hcount) - XPOS12;
  assign idx      = rel / 12'(CELL);
  assign in_range = (idx < 12'(DIGITS));

  // Digit 0 is the most significant one.
  always_comb begin
    digit = 4'd0;
    d_i   = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
    lead  = 1'b1;
    blank = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      d_i = disp_q[4*(DIGITS-1-i) +: 4];
      if (idx == 12'(i)) begin
        digit = d_i;
`ifdef LEADING_ZERO_BLANK_EN
        blank = lead && (d_i == 4'd0) && (i != DIGITS - 1);
`endif
      end
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead && (d_i == 4'd0);
`endif
    end
  end

  always_comb begin
    code_d = 12'h020;
    xpos_d = XPOS12;
    if (in_range) begin
      code_d = 12'h030 + {8'd0, digit};
      xpos_d = XPOS12 + 12'(idx * CELL);
`ifdef LEADING_ZERO_BLANK_EN
      if (blank) code_d = 12'h020;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_code_q <= 12'h020;
      char_xpos_q <= XPOS12;
    end else begin
      char_code_q <= code_d;
      char_xpos_q <= xpos_d;
    end
  end

  assign bus.char_code = char_code_q;
  assign bus.char_xpos = char_xpos_q;
  assign bus.char_ypos = 12'(YPOS);
  assign bus.num_color = COLOR;
endmodule

// File: tb/tb_char_num_gen.sv
// tb/tb_char_num_gen.sv - scoreboard bench for char_num_gen
module tb_char_num_gen;
  localparam int XP = 100;
  localparam int YP = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  bit   chk_d  = 1'b0;
  logic [23:0] sb[$];

  char_num_gen_if #(.VALUE_W(10)) bus ();

  char_num_gen #(
    .VALUE_W(10), .DIGITS(3), .PRESCALER(1),
    .XPOS(XP), .YPOS(YP), .COLOR(12'hF00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam string S0 = "  0", S7 = "  7", S5 = "  5", S88 = " 88";
`else
  localparam string S0 = "000", S7 = "007", S5 = "005", S88 = "088";
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) chk_d <= chk_en;

  // Monitor: one registered output per driven hcount.
  always @(negedge clk) begin
    if (chk_d) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got output with no expectation queued");
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        check("char_code", {20'd0, bus.char_code}, {20'd0, e[23:12]});
        check("char_xpos", {20'd0, bus.char_xpos}, {20'd0, e[11:0]});
      end
    end
  end

  task automatic sweep(input string s);
    int offs[10] = '{-1, 0, 3, 7, 8, 15, 16, 23, 24, 40};
    for (int k = 0; k < 10; k++) begin
      int off;
      logic [11:0] code, xpos;
      off = offs[k];
      if (off >= 0 && off < 24) begin
        code = 12'(s[off / 8]);
        xpos = 12'(XP + (off / 8) * 8);
      end else begin
        code = 12'h020;
        xpos = 12'(XP);
      end
      @(posedge clk); #1;
      bus.hcount = 11'(XP + off);
      chk_en = 1'b1;
      sb.push_back({code, xpos});
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    bus.hcount = 11'(XP);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic vblank_pulse();
    @(posedge clk); #1 bus.vblnk = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.vblnk = 1'b0;
    @(posedge clk); #1;
  endtask

  // second: issue an extra strobe during busy; vb_done: raise vblnk on the finishing edge.
  task automatic convert(input logic [9:0] v, input bit second, input logic [9:0] v2, input bit vb_done);
    int n = 0;
    int guard = 0;
    @(posedge clk); #1;
    bus.value = v;
    bus.value_stb = 1'b1;
    @(posedge clk); #1;
    bus.value_stb = 1'b0;
    while (guard < 40) begin
      if (bus.busy) begin
        n++;
        if (second && n == 3) begin
          bus.value = v2;
          bus.value_stb = 1'b1;
        end
        if (n == 4) bus.value_stb = 1'b0;
        if (vb_done && n == 10) bus.vblnk = 1'b1;
      end else begin
        break;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.vblnk = 1'b0;
    bus.value_stb = 1'b0;
    check($sformatf("busy_cycles v=%0d", v), n, 10);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bus.value = '0;
    bus.value_stb = 1'b0;
    bus.hcount = 11'(XP);
    bus.vblnk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_char_code", {20'd0, bus.char_code}, 32'h020);
    check("rst_char_xpos", {20'd0, bus.char_xpos}, XP);
    check("rst_busy", {31'd0, bus.busy}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("char_code_after_rst", {20'd0, bus.char_code}, {20'd0, 12'(S0[0])});
    check("char_ypos", {20'd0, bus.char_ypos}, YP);
    check("num_color", {20'd0, bus.num_color}, 32'hF00);
    sweep(S0);

    convert(10'd123, 1'b0, 10'd0, 1'b0);
    sweep(S0);
    vblank_pulse();
    sweep("123");

    convert(10'd999, 1'b0, 10'd0, 1'b0);
    vblank_pulse();
    sweep("999");

    convert(10'd7, 1'b0, 10'd0, 1'b0);
    vblank_pulse();
    sweep(S7);

    convert(10'd1000, 1'b0, 10'd0, 1'b0);
    vblank_pulse();
    sweep("999");

    convert(10'd1023, 1'b0, 10'd0, 1'b0);
    vblank_pulse();
    sweep("999");

    convert(10'd5, 1'b1, 10'd42, 1'b0);
    sweep("999");
    vblank_pulse();
    sweep(S5);

    convert(10'd88, 1'b0, 10'd0, 1'b1);
    sweep(S88);
    vblank_pulse();
    sweep(S88);

    // Reset in the 5th SHIFT cycle.
    @(posedge clk); #1;
    bus.value = 10'd321;
    bus.value_stb = 1'b1;
    @(posedge clk); #1;
    bus.value_stb = 1'b0;
    n = 0;
    for (int g = 0; g < 20 && n < 5; g++) begin
      if (bus.busy) n++;
      if (n < 5) begin
        @(posedge clk); #1;
      end
    end
    check("busy_before_rst", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    #1;
    check("busy_in_rst", {31'd0, bus.busy}, 0);
    check("code_in_rst", {20'd0, bus.char_code}, 32'h020);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep(S0);
    vblank_pulse();
    sweep(S0);

    convert(10'd456, 1'b0, 10'd0, 1'b0);
    vblank_pulse();
    sweep("456");

    repeat (3) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
